// File: rtl/invaders_pkg.sv
// -----------------------------------------------------------------------------
// invaders_pkg
// Shared constants for the invader formation: start position, playfield limits,
// column/row pitch and sprite size (also used by the invader datapath and the
// renderer), plus the march sequencer state encoding and the step-period rule.
// No ports.
// -----------------------------------------------------------------------------
package invaders_pkg;

    // Bus widths
    localparam int W_POS   = 10;  // pixel coordinate
    localparam int W_EDGE  = 11;  // edge arithmetic, wide enough to never wrap
    localparam int W_ALIVE = 6;   // live invader count, 0..55
    localparam int W_COL   = 4;   // column index, 0..10
    localparam int W_ROW   = 3;   // row index, 0..4
    localparam int W_CNT   = 7;   // frame counter / period, up to 64

    // Formation geometry
    localparam logic [W_POS-1:0] P_START_X      = 10'd96;
    localparam logic [W_POS-1:0] P_START_Y      = 10'd64;
    localparam logic [W_POS-1:0] P_STEP_X       = 10'd8;
    localparam logic [W_POS-1:0] P_STEP_DOWN    = 10'd16;
    localparam logic [W_POS-1:0] P_COL_PITCH    = 10'd32;
    localparam logic [W_POS-1:0] P_ROW_PITCH    = 10'd24;
    localparam logic [W_POS-1:0] P_INV_W        = 10'd24;
    localparam logic [W_POS-1:0] P_INV_H        = 10'd16;
    localparam logic [W_POS-1:0] P_LEFT_LIMIT   = 10'd16;
    localparam logic [W_POS-1:0] P_RIGHT_LIMIT  = 10'd624;
    localparam logic [W_POS-1:0] P_BOTTOM_LIMIT = 10'd416;
    localparam int               P_SPEED_SHIFT  = 1;

    // March sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_LANDED = 2'd3
    } march_state_t;

    // Frames between steps: fewer survivors means a faster march.
    function automatic logic [W_CNT-1:0] step_period(input logic [W_ALIVE-1:0] alive,
                                                     input int                 shift);
        logic [W_ALIVE-1:0] scaled;
        scaled = alive >> shift;
        return {1'b0, scaled} + 7'd1;
    endfunction

endpackage

// File: rtl/invader_march_ctrl_if.sv
// -----------------------------------------------------------------------------
// invader_march_ctrl_if
// Bundle between the march sequencer and the rest of the game.
//   Game -> sequencer : frame, enable, wave_start, alive_count,
//                       left_col, right_col, bottom_row
//   Sequencer -> game : invaders_x, invaders_y, step, anim, dir_left, landed
// master : the sequencer side.   slave : the game / consumer side.
// -----------------------------------------------------------------------------
interface invader_march_ctrl_if;
    import invaders_pkg::*;

    logic               frame;
    logic               enable;
    logic               wave_start;
    logic [W_ALIVE-1:0] alive_count;
    logic [W_COL-1:0]   left_col;
    logic [W_COL-1:0]   right_col;
    logic [W_ROW-1:0]   bottom_row;

    logic [W_POS-1:0]   invaders_x;
    logic [W_POS-1:0]   invaders_y;
    logic               step;
    logic               anim;
    logic               dir_left;
    logic               landed;

    modport master (
        input  frame, enable, wave_start, alive_count, left_col, right_col, bottom_row,
        output invaders_x, invaders_y, step, anim, dir_left, landed
    );

    modport slave (
        output frame, enable, wave_start, alive_count, left_col, right_col, bottom_row,
        input  invaders_x, invaders_y, step, anim, dir_left, landed
    );

endinterface

// File: rtl/march_timer.sv
// -----------------------------------------------------------------------------
// march_timer
// Counts qualified video frames and raises o_tick on the frame that completes
// the current step period. The period is taken from the live alive_count on
// that frame, so a drop in survivors can end the wait early.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_clear         : restart counting from zero (wave start)
//   i_run           : sequencer is waiting for its next step
//   i_frame         : one-cycle frame pulse
//   i_enable        : game running; frames are ignored while low
//   i_alive_count   : number of live invaders
//   o_tick          : combinational pulse on the terminal frame
// -----------------------------------------------------------------------------
module march_timer
    import invaders_pkg::*;
#(
    parameter int SPEED_SHIFT = P_SPEED_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic               i_frame,
    input  logic               i_enable,
    input  logic [W_ALIVE-1:0] i_alive_count,
    output logic               o_tick
);

    logic [W_CNT-1:0] r_count;
    logic [W_CNT-1:0] w_period;
    logic [W_CNT-1:0] w_count_inc;
    logic             w_advance;

    assign w_period    = step_period(i_alive_count, SPEED_SHIFT);
    // An empty formation never advances, so the count simply holds.
    assign w_advance   = i_run & i_frame & i_enable & (i_alive_count != '0);
    assign w_count_inc = r_count + 7'd1;
    assign o_tick      = w_advance & (w_count_inc >= w_period);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else if (w_advance) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/invader_march_ctrl.sv
// -----------------------------------------------------------------------------
// invader_march_ctrl
// Sequencer for the invader formation march. Waits a speed-dependent number of
// frames, then steps the formation origin sideways, or down with a direction
// reversal when the live columns would cross a playfield edge. Flags (sticky)
// when the lowest live row reaches the player's row.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : invader_march_ctrl_if.master
//          in : frame, enable, wave_start, alive_count, left_col, right_col,
//               bottom_row
//          out: invaders_x, invaders_y, step, anim, dir_left, landed
//               (all registered)
// -----------------------------------------------------------------------------
module invader_march_ctrl
    import invaders_pkg::*;
#(
    parameter logic [W_POS-1:0] START_X      = P_START_X,
    parameter logic [W_POS-1:0] START_Y      = P_START_Y,
    parameter logic [W_POS-1:0] STEP_X       = P_STEP_X,
    parameter logic [W_POS-1:0] STEP_DOWN    = P_STEP_DOWN,
    parameter logic [W_POS-1:0] COL_PITCH    = P_COL_PITCH,
    parameter logic [W_POS-1:0] ROW_PITCH    = P_ROW_PITCH,
    parameter logic [W_POS-1:0] INV_W        = P_INV_W,
    parameter logic [W_POS-1:0] INV_H        = P_INV_H,
    parameter logic [W_POS-1:0] LEFT_LIMIT   = P_LEFT_LIMIT,
    parameter logic [W_POS-1:0] RIGHT_LIMIT  = P_RIGHT_LIMIT,
    parameter logic [W_POS-1:0] BOTTOM_LIMIT = P_BOTTOM_LIMIT,
    parameter int               SPEED_SHIFT  = P_SPEED_SHIFT
) (
    input  logic                 clk,
    input  logic                 rst,
    invader_march_ctrl_if.master bus
);

    // Registered state and outputs
    march_state_t     r_state;
    logic [W_POS-1:0] r_x;
    logic [W_POS-1:0] r_y;
    logic             r_step;
    logic             r_anim;
    logic             r_dir_left;
    logic             r_landed;

    // Next-state values
    march_state_t     w_state_next;
    logic [W_POS-1:0] w_x_next;
    logic [W_POS-1:0] w_y_next;
    logic             w_step_next;
    logic             w_anim_next;
    logic             w_dir_next;
    logic             w_landed_next;

    // Step decision
    logic              w_tick;
    logic [W_EDGE-1:0] w_right_reach;
    logic [W_EDGE-1:0] w_left_reach;
    logic [W_EDGE-1:0] w_left_bound;
    logic [W_EDGE-1:0] w_land_reach;
    logic              w_edge_hit;
    logic [W_POS-1:0]  w_x_side;
    logic [W_POS-1:0]  w_y_down;

    // -------------------------------------------------------------------------
    // Frame timer
    // -------------------------------------------------------------------------
    march_timer #(
        .SPEED_SHIFT (SPEED_SHIFT)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (bus.wave_start),
        .i_run         (r_state == ST_WAIT),
        .i_frame       (bus.frame),
        .i_enable      (bus.enable),
        .i_alive_count (bus.alive_count),
        .o_tick        (w_tick)
    );

    // -------------------------------------------------------------------------
    // Edge arithmetic, done in 11 bits so the reach never wraps around.
    // Moving right we check whether the rightmost live column would cross the
    // right limit after one more step; moving left, whether the leftmost live
    // column is already within one step of the left limit.
    // -------------------------------------------------------------------------
    assign w_right_reach = 11'(r_x) + 11'(bus.right_col) * 11'(COL_PITCH)
                         + 11'(INV_W) + 11'(STEP_X);
    assign w_left_reach  = 11'(r_x) + 11'(bus.left_col) * 11'(COL_PITCH);
    assign w_left_bound  = 11'(LEFT_LIMIT) + 11'(STEP_X);
    assign w_edge_hit    = r_dir_left ? (w_left_reach < w_left_bound)
                                      : (w_right_reach > 11'(RIGHT_LIMIT));

    assign w_x_side      = r_dir_left ? (r_x - STEP_X) : (r_x + STEP_X);
    assign w_y_down      = r_y + STEP_DOWN;
    // Landing is judged on the post-step y of the lowest live row.
    assign w_land_reach  = 11'(w_y_down) + 11'(bus.bottom_row) * 11'(ROW_PITCH)
                         + 11'(INV_H);

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_step_next   = 1'b0;
        w_anim_next   = r_anim;
        w_dir_next    = r_dir_left;
        w_landed_next = r_landed;

        if (bus.wave_start) begin
            // Restart beats any same-cycle frame or pending step.
            w_state_next  = ST_WAIT;
            w_x_next      = START_X;
            w_y_next      = START_Y;
            w_anim_next   = 1'b0;
            w_dir_next    = 1'b0;
            w_landed_next = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (w_tick) begin
                        w_state_next = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    w_step_next  = 1'b1;
                    w_anim_next  = ~r_anim;
                    w_state_next = ST_WAIT;
                    if (w_edge_hit) begin
                        w_y_next   = w_y_down;
                        w_dir_next = ~r_dir_left;
                        if (w_land_reach >= 11'(BOTTOM_LIMIT)) begin
                            w_landed_next = 1'b1;
                            w_state_next  = ST_LANDED;
                        end
                    end else begin
                        w_x_next = w_x_side;
                    end
                end
                // IDLE and LANDED hold everything until a wave start.
                ST_IDLE, ST_LANDED: begin
                    w_state_next = r_state;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_x        <= START_X;
            r_y        <= START_Y;
            r_step     <= 1'b0;
            r_anim     <= 1'b0;
            r_dir_left <= 1'b0;
            r_landed   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_step     <= w_step_next;
            r_anim     <= w_anim_next;
            r_dir_left <= w_dir_next;
            r_landed   <= w_landed_next;
        end
    end

    assign bus.invaders_x = r_x;
    assign bus.invaders_y = r_y;
    assign bus.step       = r_step;
    assign bus.anim       = r_anim;
    assign bus.dir_left   = r_dir_left;
    assign bus.landed     = r_landed;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// -----------------------------------------------------------------------------
// tb_invader_march_ctrl
// Directed and randomized stimulus for invader_march_ctrl, checked against a
// frame-level reference model of the march rules.
// -----------------------------------------------------------------------------
module tb_invader_march_ctrl;

    logic clk;
    logic rst;

    invader_march_ctrl_if bus ();

    invader_march_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: formation state advanced once per frame.
    int m_x, m_y, m_cnt;
    bit m_dir, m_anim, m_landed, m_active;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reload();
        m_x      = 96;
        m_y      = 64;
        m_cnt    = 0;
        m_dir    = 1'b0;
        m_anim   = 1'b0;
        m_landed = 1'b0;
    endtask

    task automatic model_move();
        bit hit;
        if (!m_dir) hit = (m_x + int'(bus.right_col) * 32 + 24 + 8 > 624);
        else        hit = (m_x + int'(bus.left_col) * 32 < 16 + 8);
        m_anim = !m_anim;
        if (hit) begin
            m_y   = (m_y + 16) % 1024;
            m_dir = !m_dir;
            if (m_y + int'(bus.bottom_row) * 24 + 16 >= 416) m_landed = 1'b1;
        end else if (m_dir) begin
            m_x = (m_x - 8 + 1024) % 1024;
        end else begin
            m_x = (m_x + 8) % 1024;
        end
    endtask

    task automatic model_frame(output bit moved);
        int alive;
        alive = int'(bus.alive_count);
        moved = 1'b0;
        if (m_active && !m_landed && bus.enable && alive != 0) begin
            m_cnt++;
            if (m_cnt >= alive / 2 + 1) begin
                m_cnt = 0;
                moved = 1'b1;
                model_move();
            end
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_step);
        check({tag, ".step"},     bus.step,       exp_step);
        check({tag, ".x"},        bus.invaders_x, m_x);
        check({tag, ".y"},        bus.invaders_y, m_y);
        check({tag, ".anim"},     bus.anim,       m_anim);
        check({tag, ".dir_left"}, bus.dir_left,   m_dir);
        check({tag, ".landed"},   bus.landed,     m_landed);
    endtask

    // One frame pulse; outputs are compared two cycles later, then step must drop.
    task automatic pulse_frame(output logic seen);
        bit moved;
        @(negedge clk);
        bus.frame = 1'b1;
        @(negedge clk);
        bus.frame = 1'b0;
        model_frame(moved);
        @(negedge clk);
        seen = bus.step;
        check_outputs("frame", moved);
        @(negedge clk);
        check("frame.step_width", bus.step, 0);
    endtask

    task automatic pulse_wave();
        @(negedge clk);
        bus.wave_start = 1'b1;
        @(negedge clk);
        bus.wave_start = 1'b0;
        model_reload();
        m_active = 1'b1;
        check_outputs("wave_start", 1'b0);
    endtask

    initial begin
        logic seen;
        int   first;
        int   steps;

        rst             = 1'b1;
        bus.frame       = 1'b0;
        bus.enable      = 1'b0;
        bus.wave_start  = 1'b0;
        bus.alive_count = 6'd0;
        bus.left_col    = 4'd0;
        bus.right_col   = 4'd10;
        bus.bottom_row  = 3'd0;
        model_reload();
        m_active = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_outputs("reset", 1'b0);
        rst = 1'b0;

        // Frames in IDLE are ignored
        bus.enable      = 1'b1;
        bus.alive_count = 6'd55;
        pulse_frame(seen);

        // First step after 28 frames with 55 alive
        pulse_wave();
        first = 0;
        for (int i = 1; i <= 28; i++) begin
            pulse_frame(seen);
            if (seen === 1'b1 && first == 0) first = i;
        end
        check("first_step_frame", first, 28);
        check("first_step_x", bus.invaders_x, 104);
        check("first_step_anim", bus.anim, 1);

        // One step per frame up to the right edge, then down and reverse
        bus.alive_count = 6'd1;
        for (int i = 0; i < 40; i++) begin
            pulse_frame(seen);
            if (bus.dir_left === 1'b1) break;
        end
        check("reverse_x", bus.invaders_x, 280);
        check("reverse_y", bus.invaders_y, 80);
        check("reverse_dir", bus.dir_left, 1);
        pulse_frame(seen);
        check("left_step_x", bus.invaders_x, 272);

        // March down to y=384, then a deep bottom row makes the next drop land
        for (int i = 0; i < 2000; i++) begin
            if (m_y == 384) bus.bottom_row = 3'd4;
            pulse_frame(seen);
            if (m_landed || bus.landed === 1'b1) break;
        end
        check("landed_y", bus.invaders_y, 400);
        check("landed_flag", bus.landed, 1);
        steps = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_frame(seen);
            if (seen === 1'b1) steps++;
        end
        check("landed_frozen_steps", steps, 0);
        pulse_wave();
        check("restart_x", bus.invaders_x, 96);
        check("restart_landed", bus.landed, 0);

        // wave_start together with a terminal frame
        bus.bottom_row = 3'd0;
        repeat (3) pulse_frame(seen);
        @(negedge clk);
        bus.frame      = 1'b1;
        bus.wave_start = 1'b1;
        @(negedge clk);
        bus.frame      = 1'b0;
        bus.wave_start = 1'b0;
        model_reload();
        check_outputs("wave_vs_frame", 1'b0);
        @(negedge clk);
        check_outputs("wave_vs_frame_next", 1'b0);

        // enable low for 10 frames holds the count
        bus.alive_count = 6'd55;
        pulse_wave();
        first = 0;
        for (int i = 1; i <= 60; i++) begin
            bus.enable = !(i > 10 && i <= 20);
            pulse_frame(seen);
            if (seen === 1'b1) begin
                first = i;
                break;
            end
        end
        bus.enable = 1'b1;
        check("enable_hold_frame", first, 38);

        // No live invaders: no steps
        bus.alive_count = 6'd0;
        steps = 0;
        for (int i = 0; i < 100; i++) begin
            pulse_frame(seen);
            if (seen === 1'b1) steps++;
        end
        check("empty_steps", steps, 0);

        // Randomized play
        pulse_wave();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) pulse_wave();
            bus.alive_count = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 55))
                                                          : 6'($urandom_range(1, 6));
            bus.left_col    = 4'($urandom_range(0, 10));
            bus.right_col   = 4'($urandom_range(int'(bus.left_col), 10));
            bus.bottom_row  = 3'($urandom_range(0, 4));
            bus.enable      = ($urandom_range(0, 7) != 0);
            pulse_frame(seen);
        end

        // Reset while in DECIDE
        bus.enable      = 1'b1;
        bus.alive_count = 6'd1;
        bus.left_col    = 4'd0;
        bus.right_col   = 4'd10;
        bus.bottom_row  = 3'd0;
        pulse_wave();
        repeat (2) pulse_frame(seen);
        @(negedge clk);
        bus.frame = 1'b1;
        @(negedge clk);
        bus.frame = 1'b0;
        #2 rst = 1'b1;
        model_reload();
        m_active = 1'b0;
        #1 check_outputs("rst_in_decide", 1'b0);
        @(negedge clk);
        check_outputs("rst_in_decide_next", 1'b0);
        rst = 1'b0;
        pulse_frame(seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
